adder16_operand_sched: RTL

- Upstream feeder and result collector for the two-cycle, half-split 16-bit adder `adder16_2`.
- `adder16_2` computes the low byte at one clock edge and the high byte at the next, and it cannot stall. Its operands must therefore stay stable across two consecutive edges.
- This block accepts operand pairs on a valid/ready handshake and buffers them. It issues each pair to the adder held for exactly two cycles, tracks results through the adder latency, and returns {cout, sum} on a valid/ready output.
- A credit scheme guarantees that no in-flight result is ever dropped.

---
 rtl/adder16_sched_pkg.sv | 29 ++
 rtl/adder16_sync_fifo.sv | 69 ++++++
 rtl/adder16_operand_sched.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/adder16_sched_pkg.sv
// Shared types and constants for the adder16_2 operand scheduler.
// The adder splits a 16-bit add into a low-byte edge and a high-byte edge.
package adder16_sched_pkg;

  localparam int OP_W        = 16;
  localparam int ADD_LAT     = 2;
  localparam int HOLD_CYCLES = ADD_LAT;
  localparam int TAG_LAT     = ADD_LAT + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            cin;
  } operand_t;

  localparam int OPND_W = $bits(operand_t);
  localparam int RES_W  = OP_W + 1;

  function automatic logic [RES_W-1:0] pack_result(input logic cout, input logic [OP_W-1:0] sum);
    return {cout, sum};
  endfunction

endpackage

// File: rtl/adder16_sync_fifo.sv
// Generic synchronous FIFO with a combinational head read and async active-low reset.
// A push on a full FIFO is taken only when a pop happens on the same edge.
module adder16_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    if (ptr == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return ptr + AW'(1);
    end
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/adder16_operand_sched.sv
// Feeds adder16_2 with operand pairs held for two edges and collects its results.
// Credits bound in-flight plus buffered results to the output buffer depth.
module adder16_sched_chk #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 2,
  parameter int ICW       = 3,
  parameter int OCW       = 2,
  parameter int TL        = 3
) (
  input logic           clk,
  input logic           rst_n,
  input logic           i_out_wr,
  input logic           i_out_full,
  input logic           i_out_pop,
  input logic [OCW-1:0] i_credits,
  input logic [TL-1:0]  i_tag,
  input logic [OCW-1:0] i_out_count,
  input logic [ICW-1:0] i_in_count
);

  a_no_result_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_out_wr && i_out_full && !i_out_pop));

  a_credit_balance: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(i_credits) + $countones(i_tag) + int'(i_out_count)) == OUT_DEPTH);

  a_in_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    int'(i_in_count) <= IN_DEPTH);

endmodule

module adder16_operand_sched
  import adder16_sched_pkg::*;
#(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_a,
  input  logic [OP_W-1:0] in_b,
  input  logic            in_cin,
  output logic [OP_W-1:0] add_a,
  output logic [OP_W-1:0] add_b,
  output logic            add_cin,
  input  logic [OP_W-1:0] add_sum,
  input  logic            add_cout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_sum,
  output logic            out_cout
);

  localparam int ICW = $clog2(IN_DEPTH + 1);
  localparam int OCW = $clog2(OUT_DEPTH + 1);

  operand_t           w_in_data;
  operand_t           w_in_head;
  operand_t           r_opnd;
  logic               w_in_full;
  logic               w_in_empty;
  logic               w_in_push;
  logic [ICW-1:0]     w_in_count;
  sched_state_e       r_state;
  sched_state_e       w_state_nxt;
  logic               w_issue;
  logic               w_credit_ok;
  logic [OCW-1:0]     r_credits;
  logic [TAG_LAT-1:0] r_tag;
  logic [RES_W-1:0]   w_res_in;
  logic [RES_W-1:0]   w_res_head;
  logic               w_out_full;
  logic               w_out_empty;
  logic               w_out_wr;
  logic               w_out_pop;
  logic [OCW-1:0]     w_out_count;

  assign w_in_data.a   = in_a;
  assign w_in_data.b   = in_b;
  assign w_in_data.cin = in_cin;
  assign w_in_push     = in_valid & ~w_in_full;
  assign in_ready      = ~w_in_full;

  adder16_sync_fifo #(.WIDTH(OPND_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_in_push),
    .i_data  (w_in_data),
    .i_pop   (w_issue),
    .o_data  (w_in_head),
    .o_full  (w_in_full),
    .o_empty (w_in_empty),
    .o_count (w_in_count)
  );

  // A credit returned by a pop on this edge may be spent by an issue on the same edge.
  assign w_out_pop   = ~w_out_empty & out_ready;
  assign w_credit_ok = (r_credits != {OCW{1'b0}}) | w_out_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      IDLE, HOLD1: begin
        if (!w_in_empty && w_credit_ok) begin
          w_state_nxt = HOLD0;
          w_issue     = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_issue     = 1'b0;
        end
      end
      HOLD0:   w_state_nxt = HOLD1;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_opnd    <= {OPND_W{1'b0}};
      r_credits <= OCW'(OUT_DEPTH);
      r_tag     <= {TAG_LAT{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_tag   <= {r_tag[TAG_LAT-2:0], w_issue};
      if (w_issue) r_opnd <= w_in_head;
      case ({w_issue, w_out_pop})
        2'b10:   r_credits <= r_credits - OCW'(1);
        2'b01:   r_credits <= r_credits + OCW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign add_a   = r_opnd.a;
  assign add_b   = r_opnd.b;
  assign add_cin = r_opnd.cin;

  assign w_out_wr = r_tag[TAG_LAT-1];
  assign w_res_in = pack_result(add_cout, add_sum);

  adder16_sync_fifo #(.WIDTH(RES_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_out_wr),
    .i_data  (w_res_in),
    .i_pop   (w_out_pop),
    .o_data  (w_res_head),
    .o_full  (w_out_full),
    .o_empty (w_out_empty),
    .o_count (w_out_count)
  );

  assign out_valid           = ~w_out_empty;
  assign {out_cout, out_sum} = w_res_head;

  adder16_sched_chk #(
    .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .ICW(ICW), .OCW(OCW), .TL(TAG_LAT)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_out_wr    (w_out_wr),
    .i_out_full  (w_out_full),
    .i_out_pop   (w_out_pop),
    .i_credits   (r_credits),
    .i_tag       (r_tag),
    .i_out_count (w_out_count),
    .i_in_count  (w_in_count)
  );

endmodule
